fetch_queue: RTL and testbench

- Instruction prefetch buffer sitting directly upstream of the IF/ID pipeline register.
- Generates sequential fetch addresses to instruction memory and stores returned instructions with their PCs in a DEPTH-entry in-order queue.
- Presents entries to the decode side through a valid/ready handshake.
- Handles taken-branch redirects by flushing the queue and discarding stale in-flight responses.

---
 rtl/fetch_queue.sv | 216 +++++++++++++++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer in front of the IF/ID register.
// Issues sequential fetches, keeps returned instructions with their PCs in
// an in-order DEPTH-entry queue and hands them to decode via valid/ready.
// A taken-branch redirect flushes the queue and drains stale responses.
// Optional build macro: FETCH_QUEUE_BYPASS_EN (same-cycle response bypass
// when the queue is empty).
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc_plus4,
  output logic [31:0]              out_instruction,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0]   PTR_ZERO = {PW{1'b0}};
  localparam logic [XLEN-1:0] PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] PC_ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] fetch_pc_r;
  logic [PW-1:0]   head_r;      // oldest entry (filled or reserved)
  logic [PW-1:0]   fill_r;      // oldest reserved-but-unfilled entry
  logic [PW-1:0]   tail_r;      // next slot to reserve
  logic [CW-1:0]   level_r;     // entries holding data
  logic [CW-1:0]   inflight_r;  // live outstanding requests
  logic [CW-1:0]   drop_cnt_r;  // stale responses still to discard
  logic [XLEN-1:0] pc_mem_r   [DEPTH];
  logic [31:0]     data_mem_r [DEPTH];
  logic            out_valid_r;
  logic [XLEN-1:0] out_pc_r;
  logic [XLEN-1:0] out_pc_plus4_r;
  logic [31:0]     out_instr_r;

  logic            run_s;
  logic [CW-1:0]   reserved_s;
  logic            issue_s;
  logic            resp_s;
  logic            byp_s;
  logic            byp_pop_s;
  logic            pop_reg_s;
  logic            fill_s;
  logic [CW-1:0]   level_n_s;
  logic [CW-1:0]   inflight_n_s;
  logic [PW-1:0]   head_n_s;
  logic [XLEN-1:0] nxt_pc_s;
  logic [31:0]     nxt_ins_s;
  logic [XLEN-1:0] byp_pc_s;
  logic [XLEN-1:0] redirect_pc_s;
  logic [CW-1:0]   drop_new_s;
  logic [CW-1:0]   drain_n_s;

  // Per-cycle qualifiers: issue, accepted response, bypass and handshakes
  always_comb begin
    run_s      = (state_r == ST_RUN);
    reserved_s = level_r + inflight_r;
    issue_s    = run_s && !redirect_valid && (reserved_s < DEPTH_C);
    resp_s     = run_s && imem_rvalid && (inflight_r != CNT_ZERO);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp_s      = resp_s && (level_r == CNT_ZERO);
`else
    byp_s      = 1'b0;
`endif
    byp_pop_s  = byp_s && out_ready;
    pop_reg_s  = out_valid_r && out_ready;
    // A response is stored unless it is flushed by a redirect or bypassed out
    fill_s     = resp_s && !redirect_valid && !byp_pop_s;
    byp_pc_s   = pc_mem_r[fill_r];
    redirect_pc_s = redirect_pc & PC_ALIGN;
    drop_new_s = inflight_r - CW'(resp_s);
    drain_n_s  = drop_cnt_r - CW'(imem_rvalid && (drop_cnt_r != CNT_ZERO));
  end

  // Next-cycle occupancy and the entry that will sit at the head
  always_comb begin
    level_n_s    = level_r + CW'(fill_s) - CW'(pop_reg_s);
    inflight_n_s = inflight_r + CW'(issue_s) - CW'(resp_s);
    head_n_s     = head_r + PW'(pop_reg_s || byp_pop_s);
    nxt_pc_s     = pc_mem_r[head_n_s];
    if (fill_s && (fill_r == head_n_s)) begin
      nxt_ins_s = imem_rdata;
    end else begin
      nxt_ins_s = data_mem_r[head_n_s];
    end
  end

  // Decode-side outputs: registered head, or the live response when bypassing
  always_comb begin
    if (byp_s) begin
      out_valid       = 1'b1;
      out_pc          = byp_pc_s;
      out_pc_plus4    = byp_pc_s + PC_STEP;
      out_instruction = imem_rdata;
    end else begin
      out_valid       = out_valid_r;
      out_pc          = out_pc_r;
      out_pc_plus4    = out_pc_plus4_r;
      out_instruction = out_instr_r;
    end
  end

  assign imem_req  = issue_s;
  assign imem_addr = fetch_pc_r;
  assign level     = level_r;

  // Entry storage: PC captured at issue, instruction captured on response
  always_ff @(posedge clk) begin
    if (issue_s) begin
      pc_mem_r[tail_r] <= fetch_pc_r;
    end
    if (fill_s) begin
      data_mem_r[fill_r] <= imem_rdata;
    end
  end

  // Control FSM, queue pointers, counters and registered head outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      fetch_pc_r     <= RESET_PC;
      head_r         <= PTR_ZERO;
      fill_r         <= PTR_ZERO;
      tail_r         <= PTR_ZERO;
      level_r        <= CNT_ZERO;
      inflight_r     <= CNT_ZERO;
      drop_cnt_r     <= CNT_ZERO;
      out_valid_r    <= 1'b0;
      out_pc_r       <= {XLEN{1'b0}};
      out_pc_plus4_r <= {XLEN{1'b0}};
      out_instr_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_valid) begin
            // Any handshake this cycle completes, then everything is flushed
            head_r      <= PTR_ZERO;
            fill_r      <= PTR_ZERO;
            tail_r      <= PTR_ZERO;
            level_r     <= CNT_ZERO;
            inflight_r  <= CNT_ZERO;
            fetch_pc_r  <= redirect_pc_s;
            drop_cnt_r  <= drop_new_s;
            state_r     <= (drop_new_s != CNT_ZERO) ? ST_DRAIN : ST_RUN;
            out_valid_r <= 1'b0;
            if (byp_s) begin
              out_pc_r       <= byp_pc_s;
              out_pc_plus4_r <= byp_pc_s + PC_STEP;
              out_instr_r    <= imem_rdata;
            end
          end else begin
            head_r     <= head_n_s;
            fill_r     <= fill_r + PW'(resp_s);
            tail_r     <= tail_r + PW'(issue_s);
            level_r    <= level_n_s;
            inflight_r <= inflight_n_s;
            if (issue_s) begin
              fetch_pc_r <= fetch_pc_r + PC_STEP;
            end
            if (level_n_s != CNT_ZERO) begin
              out_valid_r    <= 1'b1;
              out_pc_r       <= nxt_pc_s;
              out_pc_plus4_r <= nxt_pc_s + PC_STEP;
              out_instr_r    <= nxt_ins_s;
            end else begin
              out_valid_r <= 1'b0;
              // Keep showing the last entry seen, including a bypassed one
              if (byp_pop_s) begin
                out_pc_r       <= byp_pc_s;
                out_pc_plus4_r <= byp_pc_s + PC_STEP;
                out_instr_r    <= imem_rdata;
              end
            end
          end
        end
        ST_DRAIN: begin
          drop_cnt_r <= drain_n_s;
          if (drain_n_s == CNT_ZERO) begin
            state_r <= ST_RUN;
          end
          if (redirect_valid) begin
            fetch_pc_r <= redirect_pc_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed stimulus for fetch_queue, checked
// every cycle against a queue-based reference model of the prefetch buffer.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;
  logic                   imem_req;
  logic [XLEN-1:0]        imem_addr;
  logic                   imem_rvalid;
  logic [31:0]            imem_rdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_pc;
  logic [XLEN-1:0]        out_pc_plus4;
  logic [31:0]            out_instruction;
  logic [$clog2(DEPTH):0] level;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(64'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .out_instruction (out_instruction),
    .level           (level)
  );

  always #5 clk = ~clk;

  typedef struct { longint unsigned due; logic [31:0] data; } mreq_t;
  typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;

  // Memory: every outstanding request, in order, with its response cycle
  mreq_t           mem_q[$];
  // Model: returned-but-unconsumed entries and live outstanding request PCs
  ent_t            ready_q[$];
  logic [63:0]     live_q[$];
  int              stale_n;
  bit              m_idle;
  logic [63:0]     m_fetch;
  logic [63:0]     last_pc;
  logic [63:0]     last_p4;
  logic [31:0]     last_ins;
  longint unsigned cyc;
  int              lat_min;
  int              lat_max;
  bit              spur_en;
  int              vectors;
  int              miscompares;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_and_update();
    bit          exp_req;
    bit          byp;
    bit          exp_valid;
    bit          pop;
    bit          was_drain;
    logic [63:0] exp_pc;
    logic [63:0] exp_p4;
    logic [31:0] exp_ins;
    logic [63:0] pc;
    exp_req = !m_idle && (stale_n == 0) && !redirect_valid &&
              ((ready_q.size() + live_q.size()) < DEPTH);
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = !m_idle && (stale_n == 0) && (ready_q.size() == 0) &&
          (live_q.size() > 0) && imem_rvalid;
`endif
    exp_valid = (ready_q.size() > 0) || byp;
    if (ready_q.size() > 0) begin
      exp_pc = ready_q[0].pc; exp_ins = ready_q[0].ins; exp_p4 = exp_pc + 64'd4;
    end else if (byp) begin
      exp_pc = live_q[0]; exp_ins = imem_rdata; exp_p4 = exp_pc + 64'd4;
    end else begin
      exp_pc = last_pc; exp_ins = last_ins; exp_p4 = last_p4;
    end
    chk("imem_req", 64'(imem_req), 64'(exp_req));
    chk("imem_addr", imem_addr, m_fetch);
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_pc", out_pc, exp_pc);
    chk("out_pc_plus4", out_pc_plus4, exp_p4);
    chk("out_instruction", 64'(out_instruction), 64'(exp_ins));
    chk("level", 64'(level), 64'(ready_q.size()));

    if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      was_drain = (stale_n > 0);
      pop = exp_valid && out_ready;
      if (pop && !byp) void'(ready_q.pop_front());
      if (imem_rvalid) begin
        if (stale_n > 0) begin
          stale_n--;
        end else if (live_q.size() > 0) begin
          pc = live_q.pop_front();
          if (!redirect_valid && !(byp && pop)) ready_q.push_back('{pc, imem_rdata});
        end
      end
      if (redirect_valid) begin
        if (!was_drain) begin
          ready_q.delete();
          stale_n = live_q.size();
          live_q.delete();
        end
        m_fetch = {redirect_pc[63:2], 2'b00};
      end
      if (exp_req) begin
        live_q.push_back(m_fetch);
        mem_q.push_back('{cyc + longint'($urandom_range(lat_max, lat_min)), $urandom});
        m_fetch = m_fetch + 64'd4;
      end
    end
    if (exp_valid) begin
      last_pc = exp_pc; last_p4 = exp_p4; last_ins = exp_ins;
    end
  endtask

  task automatic do_cycle(input logic redir, input logic [63:0] rpc, input logic rdy);
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = rdy;
    if ((mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else if (spur_en && (mem_q.size() == 0) && ($urandom_range(7, 0) == 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
    check_and_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_cycles(input int n, input int p_ready, input int p_redir);
    for (int i = 0; i < n; i++) begin
      logic [63:0] rpc;
      rpc = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) rpc[63:8] = {56{1'b1}};
      do_cycle($urandom_range(99, 0) < p_redir, rpc, $urandom_range(99, 0) < p_ready);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
    cyc = 0; lat_min = 1; lat_max = 1; spur_en = 1'b0;
    stale_n = 0; m_idle = 1'b1; m_fetch = 64'h0;
    last_pc = 64'h0; last_p4 = 64'h0; last_ins = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_imem_req", 64'(imem_req), 64'h0);
    chk("rst_imem_addr", imem_addr, 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_pc_plus4", out_pc_plus4, 64'h0);
    chk("rst_out_instruction", 64'(out_instruction), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Latency 1, decode always ready: sequential stream from address 0
    run_cycles(12, 100, 0);
    // Decode stalls: queue fills to DEPTH and issue stops
    run_cycles(10, 0, 0);
    // Decode resumes: issue continues without duplicates
    run_cycles(8, 100, 0);
    // Latency 3 with requests in flight, redirect to misaligned target
    lat_min = 3; lat_max = 3;
    run_cycles(4, 100, 0);
    do_cycle(1'b1, 64'h103, 1'b1);
    run_cycles(12, 100, 0);
    // Address wrap at the top of the PC space
    lat_min = 1; lat_max = 1;
    do_cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    run_cycles(8, 100, 0);
    // Fill the queue, then redirect in the same cycle as a handshake
    run_cycles(6, 0, 0);
    do_cycle(1'b1, 64'h40, 1'b1);
    run_cycles(8, 100, 0);
    // Randomized traffic: variable latency, stalls, redirects, stray strobes
    lat_min = 1; lat_max = 4; spur_en = 1'b1;
    run_cycles(3000, 70, 4);
    run_cycles(20, 100, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
